// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and helpers for the multi-port register file.
//   DEF_DATA_WIDTH / DEF_ADDR_WIDTH / DEF_NUM_RD : default geometry
//   STRB_W                                      : byte strobes per default word
//   merge_bytes()                               : byte-strobed word update, used
//                                                 by both the storage write path
//                                                 and the read bypass path so the
//                                                 two can never disagree.
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_NUM_RD     = 2;
  localparam int STRB_W         = DEF_DATA_WIDTH / 8;

  // merge_bytes works on a fixed maximum width so any DATA_WIDTH up to this
  // limit can share it; callers zero-extend going in and truncate coming out.
  localparam int MAX_DATA_WIDTH = 256;
  localparam int MAX_STRB_W     = MAX_DATA_WIDTH / 8;

  typedef logic [MAX_DATA_WIDTH-1:0] word_max_t;
  typedef logic [MAX_STRB_W-1:0]     strb_max_t;

  // Bytes with strobe set take the new data; all others keep the old value.
  function automatic word_max_t merge_bytes(input word_max_t old_word,
                                            input word_max_t data,
                                            input strb_max_t strb);
    word_max_t result;
    result = old_word;
    for (int b = 0; b < MAX_STRB_W; b++) begin
      if (strb[b]) result[8*b +: 8] = data[8*b +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// -----------------------------------------------------------------------------
// regfile_read_port
// One registered read port of register_file_mp.
//   clk, rst_n      : clock, async active-low reset
//   i_rd_en         : enable & read; loads the output register
//   i_addr          : read address
//   i_word          : storage word currently held at i_addr
//   i_we0/i_waddr0/i_strb0/i_wdata0 : write port 0 (already gated by enable
//                     and the zero-register rule)
//   i_we1/i_waddr1/i_strb1/i_wdata1 : write port 1 (same gating)
//   o_data          : registered read data (holds when not reading)
// -----------------------------------------------------------------------------
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_rd_en,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]   i_word,
  input  logic                    i_we0,
  input  logic [ADDR_WIDTH-1:0]   i_waddr0,
  input  logic [DATA_WIDTH/8-1:0] i_strb0,
  input  logic [DATA_WIDTH-1:0]   i_wdata0,
  input  logic                    i_we1,
  input  logic [ADDR_WIDTH-1:0]   i_waddr1,
  input  logic [DATA_WIDTH/8-1:0] i_strb1,
  input  logic [DATA_WIDTH-1:0]   i_wdata1,
  output logic [DATA_WIDTH-1:0]   o_data
);

  localparam int SW = DATA_WIDTH / 8;

  function automatic logic [DATA_WIDTH-1:0] merge_word(input logic [DATA_WIDTH-1:0] old_word,
                                                       input logic [DATA_WIDTH-1:0] data,
                                                       input logic [SW-1:0]         strb);
    return DATA_WIDTH'(merge_bytes(word_max_t'(old_word), word_max_t'(data), strb_max_t'(strb)));
  endfunction

  logic [SW-1:0]         w_strb0;
  logic [SW-1:0]         w_strb1;
  logic [DATA_WIDTH-1:0] w_fwd;
  logic [DATA_WIDTH-1:0] r_data;

  // Bypass: apply same-cycle writes to the stored word in port order, so a
  // read returns exactly what storage will hold after this edge.
  assign w_strb0 = (i_we0 && (i_waddr0 == i_addr)) ? i_strb0 : '0;
  assign w_strb1 = (i_we1 && (i_waddr1 == i_addr)) ? i_strb1 : '0;

  // NOTE: w_fwd gets an unconditional value before the override so this
  // block stays purely combinational and cannot infer a latch.
  always_comb begin
    w_fwd = merge_word(merge_word(i_word, i_wdata0, w_strb0), i_wdata1, w_strb1);
    if (ZERO_REG && (i_addr == '0)) w_fwd = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (i_rd_en) begin
      r_data <= w_fwd;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/register_file_mp.sv
// -----------------------------------------------------------------------------
// register_file_mp
// Multi-port register file: two byte-strobed write ports, NUM_RD registered
// read ports with read-during-write forwarding, optional hardwired-zero r0.
//   clock, reset          : clock, async active-low reset (clears everything)
//   enable                : global enable for reads and writes
//   write0/select_in0/strb0/in0 : write port 0
//   write1/select_in1/strb1/in1 : write port 1 (wins on overlapping bytes)
//   read, select_out      : read request and packed read addresses
//   out, out_valid        : packed registered read data, one-cycle valid
// -----------------------------------------------------------------------------
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_RD     = DEF_NUM_RD,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         write0,
  input  logic [ADDR_WIDTH-1:0]        select_in0,
  input  logic [DATA_WIDTH/8-1:0]      strb0,
  input  logic [DATA_WIDTH-1:0]        in0,
  input  logic                         write1,
  input  logic [ADDR_WIDTH-1:0]        select_in1,
  input  logic [DATA_WIDTH/8-1:0]      strb1,
  input  logic [DATA_WIDTH-1:0]        in1,
  input  logic                         read,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] select_out,
  output logic [NUM_RD*DATA_WIDTH-1:0] out,
  output logic                         out_valid
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int SW    = DATA_WIDTH / 8;

  function automatic logic [DATA_WIDTH-1:0] merge_word(input logic [DATA_WIDTH-1:0] old_word,
                                                       input logic [DATA_WIDTH-1:0] data,
                                                       input logic [SW-1:0]         strb);
    return DATA_WIDTH'(merge_bytes(word_max_t'(old_word), word_max_t'(data), strb_max_t'(strb)));
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  r_out_valid;
  logic                  w_we0;
  logic                  w_we1;
  logic                  w_rd_en;
  logic [DATA_WIDTH-1:0] w_rd_data [NUM_RD];

  // Writes to r0 are dropped here when it is hardwired, so r0 stays at its
  // reset value of zero and the read ports see no bypass hit on it either.
  assign w_we0   = enable && write0 && !(ZERO_REG && (select_in0 == '0));
  assign w_we1   = enable && write1 && !(ZERO_REG && (select_in1 == '0));
  assign w_rd_en = enable && read;

  // NOTE: the storage array is reset because the interface promises every
  // register reads 0 after reset; a reset-free RAM would not honour that.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_out_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking updates here mean every row and every read port
      // sample pre-edge state; forwarding is handled explicitly instead.
      r_out_valid <= w_rd_en;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= merge_word(
                      merge_word(r_mem[i], in0,
                                 (w_we0 && (select_in0 == ADDR_WIDTH'(i))) ? strb0 : '0),
                      in1,
                      (w_we1 && (select_in1 == ADDR_WIDTH'(i))) ? strb1 : '0);
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_addr;
    assign w_addr = select_out[k*ADDR_WIDTH +: ADDR_WIDTH];

    regfile_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG   (ZERO_REG)
    ) u_rd (
      .clk      (clock),
      .rst_n    (reset),
      .i_rd_en  (w_rd_en),
      .i_addr   (w_addr),
      .i_word   (r_mem[w_addr]),
      .i_we0    (w_we0),
      .i_waddr0 (select_in0),
      .i_strb0  (strb0),
      .i_wdata0 (in0),
      .i_we1    (w_we1),
      .i_waddr1 (select_in1),
      .i_strb1  (strb1),
      .i_wdata1 (in1),
      .o_data   (w_rd_data[k])
    );
  end

  always_comb begin
    out = '0;
    for (int k = 0; k < NUM_RD; k++) out[k*DATA_WIDTH +: DATA_WIDTH] = w_rd_data[k];
  end

  assign out_valid = r_out_valid;

endmodule
